// File: rtl/dosing_sequencer_if.sv
// Order/motor bus for the dosing sequencer.
//   master : order source and motor observer (drives orders and abort)
//   slave  : the sequencer (accepts orders, drives motors and status)
// Signals: in_valid/in_ready order handshake, in_r/in_g/in_b dose amounts,
//   abort cancels the running order, motor_en one-hot motor enables,
//   busy high outside IDLE, done one-cycle completion pulse.
interface dosing_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_r;
  logic [4:0] in_g;
  logic [4:0] in_b;
  logic       abort;
  logic [2:0] motor_en;
  logic       busy;
  logic       done;

  modport master (
    output in_valid, in_r, in_g, in_b, abort,
    input  in_ready, motor_en, busy, done
  );

  modport slave (
    input  in_valid, in_r, in_g, in_b, abort,
    output in_ready, motor_en, busy, done
  );
endinterface

// File: rtl/dosing_sequencer.sv
// Dosing sequencer: queues R/G/B dose orders in a DEPTH-entry FIFO and runs the
// R, G and B motors in turn for amount*TICK_DIV cycles each.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - dosing_sequencer_if.slave (order handshake, abort, motors, status)
module dosing_sequencer #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned DEPTH    = 4
) (
  input logic              clk,
  input logic              rst,
  dosing_sequencer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {StIdle, StLoad, StRunR, StRunG, StRunB, StDone} state_e;

  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [4:0]  amt_r_q, amt_r_d, amt_g_q, amt_g_d, amt_b_q, amt_b_d;
  logic [2:0]  motor_en_q, motor_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [14:0] mem_q [DEPTH];

  logic        full, empty, push, pop;
  logic [4:0]  cur_amt;
  logic [8:0]  phase_len;
  logic        phase_last;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = bus.in_valid && !full;
  assign pop   = (state_q == StLoad);

  assign bus.in_ready = !full;
  assign bus.motor_en = motor_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  always_comb begin
    cur_amt = 5'd0;
    unique case (state_q)
      StRunR:  cur_amt = amt_r_q;
      StRunG:  cur_amt = amt_g_q;
      StRunB:  cur_amt = amt_b_q;
      default: cur_amt = 5'd0;
    endcase
  end

  // A zero amount still spends one cycle in its phase.
  assign phase_len  = 9'(cur_amt) * 9'(TICK_DIV);
  assign phase_last = (cur_amt == 5'd0) || (cnt_q == phase_len - 9'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    amt_r_d  = amt_r_q;
    amt_g_d  = amt_g_q;
    amt_b_d  = amt_b_q;
    wr_ptr_d = push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = 9'd0;
        if (!empty) state_d = StLoad;
      end
      StLoad: begin
        // The head is popped even on abort, so an aborted LOAD drops its order.
        {amt_r_d, amt_g_d, amt_b_d} = mem_q[rd_ptr_q[AW-1:0]];
        cnt_d   = 9'd0;
        state_d = bus.abort ? StIdle : StRunR;
      end
      StRunR, StRunG, StRunB: begin
        if (bus.abort) begin
          state_d = StIdle;
          cnt_d   = 9'd0;
        end else if (phase_last) begin
          cnt_d = 9'd0;
          unique case (state_q)
            StRunR:  state_d = StRunG;
            StRunG:  state_d = StRunB;
            default: state_d = StDone;
          endcase
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      StDone: begin
        cnt_d   = 9'd0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = 9'd0;
        state_d = StIdle;
      end
    endcase

    // Outputs are registered alongside the state they describe.
    motor_en_d = 3'b000;
    unique case (state_d)
      StRunR:  motor_en_d = {2'b00, amt_r_d != 5'd0};
      StRunG:  motor_en_d = {1'b0, amt_g_d != 5'd0, 1'b0};
      StRunB:  motor_en_d = {amt_b_d != 5'd0, 2'b00};
      default: motor_en_d = 3'b000;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= 9'd0;
      amt_r_q    <= 5'd0;
      amt_g_q    <= 5'd0;
      amt_b_q    <= 5'd0;
      motor_en_q <= 3'b000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      amt_r_q    <= amt_r_d;
      amt_g_q    <= amt_g_d;
      amt_b_q    <= amt_b_d;
      motor_en_q <= motor_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Queue storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.in_r, bus.in_g, bus.in_b};
  end

endmodule
